// File: rtl/regfile_rdmux_pipe.sv
// regfile_rdmux_pipe
// Register file merged with the operand-select mux. It feeds the ALU input
// stage with registered operands, so read data appears one cycle after the request.
// Features:
//   - two read ports (A/B), one write port
//   - same-cycle write-to-read bypass
//   - reads of PC_IDX return i_pc + PC_OFFSET (fetch read-ahead)
//   - writes to PC_IDX are redirected to o_pc_we/o_pc_wdata
//   - a stall hold that keeps held operands coherent with later writes
// Optional build macro: REGFILE_THIRD_PORT_EN adds read port C
// (i_raddr_c / o_rd_c). Port C shares o_rd_valid with A and B.

`timescale 1ns/1ps

module regfile_rdmux_pipe #(
    parameter int DATA_W    = 32,
    parameter int NUM_REGS  = 16,
    parameter int ADDR_W    = 4,
    parameter int PC_IDX    = 15,
    parameter int PC_OFFSET = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [DATA_W-1:0] i_pc,
    input  logic              i_rd_req,
    input  logic [ADDR_W-1:0] i_raddr_a,
    input  logic [ADDR_W-1:0] i_raddr_b,
`ifdef REGFILE_THIRD_PORT_EN
    input  logic [ADDR_W-1:0] i_raddr_c,
    output logic [DATA_W-1:0] o_rd_c,
`endif
    input  logic              i_stall,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rd_a,
    output logic [DATA_W-1:0] o_rd_b,
    output logic              o_rd_valid,
    output logic              o_pc_we,
    output logic [DATA_W-1:0] o_pc_wdata
);

    localparam logic [ADDR_W-1:0] PC_IDX_A    = ADDR_W'(PC_IDX);
    localparam logic [DATA_W-1:0] PC_OFFSET_D = DATA_W'(PC_OFFSET);

    // An index is backed by storage only when it is below NUM_REGS.
    // Indices that are not backed by storage read as zero and drop writes.
    function automatic logic inRange(input logic [ADDR_W-1:0] idx);
        return (32'(idx) < 32'(NUM_REGS));
    endfunction

    // Operand priority:
    //   1. the PC index returns the read-ahead PC
    //   2. a same-edge write to this index is bypassed
    //   3. otherwise the stored value is used (zero for indices without storage)
    function automatic logic [DATA_W-1:0] selectOperand(
        input logic [ADDR_W-1:0] idx,
        input logic [DATA_W-1:0] pcAhead,
        input logic              weV,
        input logic [ADDR_W-1:0] waddrV,
        input logic [DATA_W-1:0] wdataV,
        input logic [DATA_W-1:0] storedV
    );
        if (idx == PC_IDX_A) begin
            return pcAhead;
        end
        if (weV && (waddrV == idx)) begin
            return wdataV;
        end
        return storedV;
    endfunction

    // During a stall, a held operand tracks writes to its latched index.
    // The PC index is never a storage target.
    // Indices without storage drop the write, so they are excluded here too.
    function automatic logic coherentHit(
        input logic [ADDR_W-1:0] idx,
        input logic              weV,
        input logic [ADDR_W-1:0] waddrV
    );
        return weV && (waddrV == idx) && (idx != PC_IDX_A) && inRange(idx);
    endfunction

    logic [DATA_W-1:0] regsQ [NUM_REGS];

    logic [DATA_W-1:0] rdAQ, rdAD;
    logic [DATA_W-1:0] rdBQ, rdBD;
    logic [ADDR_W-1:0] idxAQ, idxAD;
    logic [ADDR_W-1:0] idxBQ, idxBD;
    logic              validQ, validD;
    logic              pcWeQ, pcWeD;
    logic [DATA_W-1:0] pcWdataQ, pcWdataD;

    logic              regWrEn;
    logic [DATA_W-1:0] pcAhead;
    logic [DATA_W-1:0] storedA;
    logic [DATA_W-1:0] storedB;

`ifdef REGFILE_THIRD_PORT_EN
    logic [DATA_W-1:0] rdCQ, rdCD;
    logic [ADDR_W-1:0] idxCQ, idxCD;
    logic [DATA_W-1:0] storedC;
`endif

    // Storage is written only for in-range, non-PC indices.
    // Stalls never block the write.
    always_comb begin
        regWrEn = i_we && (i_waddr != PC_IDX_A) && inRange(i_waddr);
        pcAhead = i_pc + PC_OFFSET_D;
    end

    // Stored values seen by each read port before any bypass applies.
    always_comb begin
        storedA = '0;
        storedB = '0;
        if (inRange(i_raddr_a)) begin
            storedA = regsQ[i_raddr_a];
        end
        if (inRange(i_raddr_b)) begin
            storedB = regsQ[i_raddr_b];
        end
    end

`ifdef REGFILE_THIRD_PORT_EN
    // Stored value seen by port C before any bypass applies.
    always_comb begin
        storedC = '0;
        if (inRange(i_raddr_c)) begin
            storedC = regsQ[i_raddr_c];
        end
    end
`endif

    // Register array update. Reset clears every entry.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regsQ[i] <= '0;
            end
        end else if (regWrEn) begin
            regsQ[i_waddr] <= i_wdata;
        end
    end

    // Redirected PC write.
    // o_pc_we is a one-cycle pulse; o_pc_wdata keeps the last redirected value.
    always_comb begin
        pcWeD    = i_we && (i_waddr == PC_IDX_A);
        pcWdataD = pcWdataQ;
        if (pcWeD) begin
            pcWdataD = i_wdata;
        end
    end

    // Read pipeline next state.
    //   - A request (no stall) latches the indices and captures fresh operands.
    //   - An idle edge (no stall) only drops valid.
    //   - A stall freezes everything except coherency updates from writes.
    always_comb begin
        rdAD   = rdAQ;
        rdBD   = rdBQ;
        idxAD  = idxAQ;
        idxBD  = idxBQ;
        validD = validQ;
        if (!i_stall) begin
            if (i_rd_req) begin
                idxAD  = i_raddr_a;
                idxBD  = i_raddr_b;
                validD = 1'b1;
                rdAD   = selectOperand(i_raddr_a, pcAhead, i_we, i_waddr, i_wdata, storedA);
                rdBD   = selectOperand(i_raddr_b, pcAhead, i_we, i_waddr, i_wdata, storedB);
            end else begin
                validD = 1'b0;
            end
        end else begin
            if (coherentHit(idxAQ, i_we, i_waddr)) begin
                rdAD = i_wdata;
            end
            if (coherentHit(idxBQ, i_we, i_waddr)) begin
                rdBD = i_wdata;
            end
        end
    end

`ifdef REGFILE_THIRD_PORT_EN
    // Port C next state follows the same request/stall rules as ports A and B.
    always_comb begin
        rdCD  = rdCQ;
        idxCD = idxCQ;
        if (!i_stall) begin
            if (i_rd_req) begin
                idxCD = i_raddr_c;
                rdCD  = selectOperand(i_raddr_c, pcAhead, i_we, i_waddr, i_wdata, storedC);
            end
        end else if (coherentHit(idxCQ, i_we, i_waddr)) begin
            rdCD = i_wdata;
        end
    end

    // Port C state registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rdCQ  <= '0;
            idxCQ <= '0;
        end else begin
            rdCQ  <= rdCD;
            idxCQ <= idxCD;
        end
    end

    assign o_rd_c = rdCQ;
`endif

    // Read pipeline and PC-redirect state registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rdAQ     <= '0;
            rdBQ     <= '0;
            idxAQ    <= '0;
            idxBQ    <= '0;
            validQ   <= 1'b0;
            pcWeQ    <= 1'b0;
            pcWdataQ <= '0;
        end else begin
            rdAQ     <= rdAD;
            rdBQ     <= rdBD;
            idxAQ    <= idxAD;
            idxBQ    <= idxBD;
            validQ   <= validD;
            pcWeQ    <= pcWeD;
            pcWdataQ <= pcWdataD;
        end
    end

    assign o_rd_a     = rdAQ;
    assign o_rd_b     = rdBQ;
    assign o_rd_valid = validQ;
    assign o_pc_we    = pcWeQ;
    assign o_pc_wdata = pcWdataQ;

endmodule

// File: tb/tb_regfile_rdmux_pipe.sv
// tb_regfile_rdmux_pipe
// Scoreboard bench for regfile_rdmux_pipe, built with the default configuration
// (port C absent).
// The stimulus side:
//   - drives one cycle of inputs at each falling edge
//   - advances a behavioural model
//   - pushes the expected post-edge outputs into a queue
// A separate monitor pops one entry after every rising edge and compares it.

`timescale 1ns/1ps

module tb_regfile_rdmux_pipe;

    typedef struct packed {
        logic        valid;
        logic [31:0] a;
        logic [31:0] b;
        logic        pcWe;
        logic [31:0] pcWdata;
    } snap_t;

    logic        clk;
    logic        rst;
    logic [31:0] pc;
    logic        rdReq;
    logic [3:0]  raddrA;
    logic [3:0]  raddrB;
    logic        stall;
    logic        we;
    logic [3:0]  waddr;
    logic [31:0] wdata;
    logic [31:0] rdA;
    logic [31:0] rdB;
    logic        rdValid;
    logic        pcWe;
    logic [31:0] pcWdata;

    int compareCount = 0;
    int failCount    = 0;

    snap_t sb[$];

    // Behavioural model state: architectural registers plus what the outputs should show.
    logic [31:0] refRegs [16];
    logic        mValid;
    logic [31:0] mA;
    logic [31:0] mB;
    logic [3:0]  mLatA;
    logic [3:0]  mLatB;
    logic [31:0] mPcWdata;

    regfile_rdmux_pipe dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_pc       (pc),
        .i_rd_req   (rdReq),
        .i_raddr_a  (raddrA),
        .i_raddr_b  (raddrB),
        .i_stall    (stall),
        .i_we       (we),
        .i_waddr    (waddr),
        .i_wdata    (wdata),
        .o_rd_a     (rdA),
        .o_rd_b     (rdB),
        .o_rd_valid (rdValid),
        .o_pc_we    (pcWe),
        .o_pc_wdata (pcWdata)
    );

    // 100 MHz clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Compares one value, counts it, and reports any difference.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compareCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Puts the model back to its power-on state.
    task automatic resetModel();
        for (int i = 0; i < 16; i++) begin
            refRegs[i] = 32'd0;
        end
        mValid   = 1'b0;
        mA       = 32'd0;
        mB       = 32'd0;
        mLatA    = 4'd0;
        mLatB    = 4'd0;
        mPcWdata = 32'd0;
    endtask

    // Architectural value of a register as seen by a read on this edge.
    function automatic logic [31:0] refRead(
        input logic [3:0]  idx,
        input logic        weV,
        input logic [3:0]  waddrV,
        input logic [31:0] wdataV,
        input logic [31:0] pcV
    );
        if (idx == 4'd15) return pcV + 32'd8;
        if (weV && waddrV == idx) return wdataV;
        return refRegs[idx];
    endfunction

    // Drives one cycle of stimulus at the falling edge and queues the expected result.
    task automatic applyStimulus(
        input logic        reqV,
        input logic [3:0]  raV,
        input logic [3:0]  rbV,
        input logic        stallV,
        input logic        weV,
        input logic [3:0]  waddrV,
        input logic [31:0] wdataV,
        input logic [31:0] pcV
    );
        snap_t exp;
        @(negedge clk);
        rst    = 1'b0;
        rdReq  = reqV;
        raddrA = raV;
        raddrB = rbV;
        stall  = stallV;
        we     = weV;
        waddr  = waddrV;
        wdata  = wdataV;
        pc     = pcV;

        exp.pcWe = weV && (waddrV == 4'd15);
        if (exp.pcWe) mPcWdata = wdataV;
        if (!stallV) begin
            if (reqV) begin
                mLatA  = raV;
                mLatB  = rbV;
                mValid = 1'b1;
                mA     = refRead(raV, weV, waddrV, wdataV, pcV);
                mB     = refRead(rbV, weV, waddrV, wdataV, pcV);
            end else begin
                mValid = 1'b0;
            end
        end else begin
            if (weV && waddrV != 4'd15 && waddrV == mLatA) mA = wdataV;
            if (weV && waddrV != 4'd15 && waddrV == mLatB) mB = wdataV;
        end
        if (weV && waddrV != 4'd15) refRegs[waddrV] = wdataV;

        exp.valid   = mValid;
        exp.a       = mA;
        exp.b       = mB;
        exp.pcWdata = mPcWdata;
        sb.push_back(exp);
    endtask

    // Waits until just after the next rising edge, so outputs have settled.
    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Asserts reset between edges and checks that outputs clear without a clock.
    // The next applyStimulus call releases reset.
    task automatic pulseReset();
        #2;
        rst   = 1'b1;
        rdReq = 1'b0;
        stall = 1'b0;
        we    = 1'b0;
        sb.delete();
        resetModel();
        #1;
        checkOutput("asyncRstValid", 32'(rdValid), 32'd0);
        checkOutput("asyncRstA", rdA, 32'd0);
        checkOutput("asyncRstB", rdB, 32'd0);
        checkOutput("asyncRstPcWe", 32'(pcWe), 32'd0);
        checkOutput("asyncRstPcWdata", pcWdata, 32'd0);
    endtask

    // Monitor: after every rising edge out of reset, pop and compare one expected snapshot.
    initial begin
        snap_t exp;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                if (sb.size() == 0) begin
                    checkOutput("sbUnderflow", 32'd1, 32'd0);
                end else begin
                    exp = sb.pop_front();
                    checkOutput("sbValid", 32'(rdValid), 32'(exp.valid));
                    checkOutput("sbRdA", rdA, exp.a);
                    checkOutput("sbRdB", rdB, exp.b);
                    checkOutput("sbPcWe", 32'(pcWe), 32'(exp.pcWe));
                    checkOutput("sbPcWdata", pcWdata, exp.pcWdata);
                end
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #2_000_000;
        failCount++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

    // Directed scenarios, then randomized traffic.
    initial begin
        logic [31:0] rpc;
        rst    = 1'b0;
        pc     = 32'd0;
        rdReq  = 1'b0;
        raddrA = 4'd0;
        raddrB = 4'd0;
        stall  = 1'b0;
        we     = 1'b0;
        waddr  = 4'd0;
        wdata  = 32'd0;
        resetModel();
        #1 rst = 1'b1;
        #2;
        checkOutput("rstValid", 32'(rdValid), 32'd0);
        checkOutput("rstA", rdA, 32'd0);
        checkOutput("rstB", rdB, 32'd0);
        checkOutput("rstPcWe", 32'(pcWe), 32'd0);
        checkOutput("rstPcWdata", pcWdata, 32'd0);
        @(negedge clk);
        @(negedge clk);

        // Reset then read: A=3, B=7 return zeros.
        applyStimulus(1, 4'd3, 4'd7, 0, 0, 4'd0, 32'd0, 32'd0);
        settle();
        checkOutput("firstReadValid", 32'(rdValid), 32'd1);
        checkOutput("firstReadA", rdA, 32'd0);
        checkOutput("firstReadB", rdB, 32'd0);

        // Write then read.
        applyStimulus(0, 4'd0, 4'd0, 0, 1, 4'd3, 32'hDEADBEEF, 32'd0);
        settle();
        checkOutput("idleValid", 32'(rdValid), 32'd0);
        applyStimulus(1, 4'd3, 4'd0, 0, 0, 4'd0, 32'd0, 32'd0);
        settle();
        checkOutput("writeReadA", rdA, 32'hDEADBEEF);

        // Bypass: a same-edge write is seen by both ports.
        applyStimulus(1, 4'd5, 4'd5, 0, 1, 4'd5, 32'h12345678, 32'd0);
        settle();
        checkOutput("bypassA", rdA, 32'h12345678);
        checkOutput("bypassB", rdB, 32'h12345678);

        // PC index reads, including wrap-around.
        applyStimulus(1, 4'd15, 4'd3, 0, 0, 4'd0, 32'd0, 32'h00000100);
        settle();
        checkOutput("pcReadA", rdA, 32'h00000108);
        applyStimulus(1, 4'd15, 4'd15, 0, 0, 4'd0, 32'd0, 32'hFFFFFFFC);
        settle();
        checkOutput("pcWrapA", rdA, 32'h00000004);

        // Writes to R15 are redirected to the PC outputs.
        applyStimulus(0, 4'd0, 4'd0, 0, 1, 4'd15, 32'h00002000, 32'h00000100);
        settle();
        checkOutput("pcWePulse", 32'(pcWe), 32'd1);
        checkOutput("pcWdataVal", pcWdata, 32'h00002000);
        applyStimulus(1, 4'd15, 4'd0, 0, 0, 4'd0, 32'd0, 32'h00000100);
        settle();
        checkOutput("pcWeDrop", 32'(pcWe), 32'd0);
        checkOutput("pcWdataHold", pcWdata, 32'h00002000);
        checkOutput("pcAfterWriteA", rdA, 32'h00000108);

        // Stall hold and coherency.
        applyStimulus(0, 4'd0, 4'd0, 0, 1, 4'd2, 32'h00000011, 32'd0);
        applyStimulus(1, 4'd2, 4'd2, 0, 0, 4'd0, 32'd0, 32'd0);
        settle();
        checkOutput("preStallA", rdA, 32'h00000011);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 4'd4, 4'd4, 1, 0, 4'd0, 32'd0, 32'd0);
            settle();
            checkOutput("stallHoldA", rdA, 32'h00000011);
            checkOutput("stallHoldValid", 32'(rdValid), 32'd1);
        end
        applyStimulus(1, 4'd4, 4'd4, 1, 1, 4'd2, 32'h00000022, 32'd0);
        settle();
        checkOutput("stallCoherentA", rdA, 32'h00000022);
        checkOutput("stallCoherentB", rdB, 32'h00000022);

        // Async reset mid-read: the pending request is aborted and R3 reads zero.
        applyStimulus(1, 4'd3, 4'd3, 0, 0, 4'd0, 32'd0, 32'd0);
        pulseReset();
        @(negedge clk);
        applyStimulus(1, 4'd3, 4'd7, 0, 0, 4'd0, 32'd0, 32'd0);
        settle();
        checkOutput("postRstR3", rdA, 32'd0);
        checkOutput("postRstValid", 32'(rdValid), 32'd1);

        // Randomized traffic; the monitor checks every edge.
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                pulseReset();
            end
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF8 + 32'($urandom_range(0, 7))) : $urandom;
            applyStimulus(($urandom_range(0, 3) != 0),
                          4'($urandom), 4'($urandom),
                          ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 1) == 1),
                          4'($urandom), $urandom, rpc);
        end
        settle();
        checkOutput("sbDrain", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
